// File: rtl/rotate_seq_ctrl.sv
// Multi-pass sequencer for a 4-bit rotate-right barrel rotator: accepts commands, loops the rotator output back.
// Optional macro ROT_SEQ_FASTPATH_EN: operands invariant under rotation finish in one cycle without using the rotator.
module rotate_seq_ctrl #(
    parameter int DATA_W = 4,
    parameter int PASS_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_amt,
    input  logic              in_dir,
    input  logic [PASS_W-1:0] in_passes,
    output logic [DATA_W-1:0] sh_a,
    output logic [1:0]        sh_s,
    input  logic [DATA_W-1:0] sh_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    if (DATA_W != 4) begin : g_width_check
        $error("rotate_seq_ctrl: DATA_W must be 4 to match the rotator");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PASS_W-1:0] CNT_ONE  = PASS_W'(1);
    localparam logic [PASS_W-1:0] CNT_ZERO = '0;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_work;
    logic [DATA_W-1:0]   r_out_data;
    logic [1:0]          r_amt;
    logic [PASS_W-1:0]   r_cnt;
    logic [1:0]          w_amt_eff;
    logic                w_accept;
    logic                w_skip;

    // Left rotation by k is right rotation by (4 - k) mod 4; the 2-bit wrap does the mod.
    assign w_amt_eff = in_dir ? (2'd0 - in_amt) : in_amt;
    assign w_accept  = in_valid && in_ready;

`ifdef ROT_SEQ_FASTPATH_EN
    assign w_skip = (in_passes == CNT_ZERO) || (in_data == '0) || (in_data == '1)
                 || (w_amt_eff == 2'd0);
`else
    assign w_skip = (in_passes == CNT_ZERO);
`endif

    assign sh_a     = r_work;
    assign out_data = r_out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        sh_s      = 2'd0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_next = w_skip ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                sh_s = r_amt;
                if (r_cnt == CNT_ONE) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Work register follows the rotator each RUN cycle; the last pass lands directly in out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work     <= '0;
            r_out_data <= '0;
            r_amt      <= 2'd0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_work <= in_data;
                        r_amt  <= w_amt_eff;
                        r_cnt  <= in_passes;
                        if (w_skip) begin
                            r_out_data <= in_data;
                        end
                    end
                end
                RUN: begin
                    r_work <= sh_y;
                    r_cnt  <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_out_data <= sh_y;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Bench for rotate_seq_ctrl: behavioural rotator on sh_a/sh_s, scoreboard of expected results and latencies.
module tb_rotate_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] in_amt;
    logic       in_dir;
    logic [2:0] in_passes;
    logic [3:0] sh_a;
    logic [1:0] sh_s;
    logic [3:0] sh_y;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       busy;

    typedef struct {
        logic [3:0] data;
        int         acc;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    logic ov_prev = 1'b0;
    logic [3:0] held;

    rotate_seq_ctrl #(.DATA_W(4), .PASS_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_dir(in_dir), .in_passes(in_passes),
        .sh_a(sh_a), .sh_s(sh_s), .sh_y(sh_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] ror4(input logic [3:0] a, input logic [1:0] s);
        logic [7:0] t;
        t = {a, a} >> s;
        return t[3:0];
    endfunction

    // Behavioural barrel rotator sitting downstream of the sequencer.
    assign sh_y = ror4(sh_a, sh_s);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] d, input logic [1:0] amt, input logic dir,
                                   input logic [2:0] passes, input int acc);
        exp_t       e;
        logic [1:0] eff;
        logic [3:0] r;
        eff = dir ? (2'd0 - amt) : amt;
        r   = d;
        for (int i = 0; i < int'(passes); i++) r = ror4(r, eff);
        e.data = r;
        e.acc  = acc;
        e.lat  = int'(passes) + 1;
`ifdef ROT_SEQ_FASTPATH_EN
        if (d == 4'h0 || d == 4'hF || eff == 2'd0) e.lat = 1;
`endif
        return e;
    endfunction

    // Push on accept, pop and compare on result handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) rise_cyc = cyc;
            ov_prev = out_valid;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_result", 32'(out_data), 32'hFFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("result_data", 32'(out_data), 32'(e.data));
                    check_eq("result_latency", 32'(rise_cyc - e.acc), 32'(e.lat));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_data, in_amt, in_dir, in_passes, cyc));
        end
    end

    task automatic send(input logic [3:0] d, input logic [1:0] amt, input logic dir, input logic [2:0] p);
        bit ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_amt = amt; in_dir = dir; in_passes = p;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check_eq("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = ~d; in_amt = amt + 2'd1; in_dir = ~dir; in_passes = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) check_eq("valid_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy && !out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) check_eq("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; in_amt = 2'd0; in_dir = 1'b0;
        in_passes = 3'd0; out_ready = 1'b1;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_out_data", 32'(out_data), 0);
        check_eq("rst_sh_s", 32'(sh_s), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_eq("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // 1100 ror 1, one pass
        send(4'b1100, 2'd1, 1'b0, 3'd1);
        check_eq("t1_busy", 32'(busy), 1);
        check_eq("t1_in_ready", 32'(in_ready), 0);
        check_eq("t1_sh_s", 32'(sh_s), 1);
        check_eq("t1_sh_a", 32'(sh_a), 32'hC);
        @(posedge clk); #1;
        check_eq("t1_out_valid", 32'(out_valid), 1);
        check_eq("t1_out_data", 32'(out_data), 32'h6);
        wait_idle();

        // 1100 rol 1
        send(4'b1100, 2'd1, 1'b1, 3'd1);
        check_eq("t2_sh_s", 32'(sh_s), 3);
        @(posedge clk); #1;
        check_eq("t2_out_data", 32'(out_data), 32'h9);
        wait_idle();

        // 0001 ror 1, three passes
        send(4'b0001, 2'd1, 1'b0, 3'd3);
        check_eq("t3_y1", 32'(sh_y), 32'h8);
        @(posedge clk); #1;
        check_eq("t3_y2", 32'(sh_y), 32'h4);
        @(posedge clk); #1;
        check_eq("t3_y3", 32'(sh_y), 32'h2);
        check_eq("t3_not_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
        check_eq("t3_out_valid", 32'(out_valid), 1);
        check_eq("t3_out_data", 32'(out_data), 32'h2);
        wait_idle();

        // pass-through
        send(4'b1010, 2'd3, 1'b0, 3'd0);
        check_eq("t4_sh_s", 32'(sh_s), 0);
        check_eq("t4_out_valid", 32'(out_valid), 1);
        check_eq("t4_out_data", 32'(out_data), 32'hA);
        wait_idle();

        // backpressure with a queued command waiting upstream
        out_ready = 1'b0;
        send(4'b0110, 2'd2, 1'b0, 3'd1);
        wait_valid();
        held = out_data;
        check_eq("t5_held", 32'(held), 32'h9);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 4'b1001; in_amt = 2'd1; in_dir = 1'b0; in_passes = 3'd1;
        for (int i = 0; i < 5; i++) begin
            check_eq("t5_stall_valid", 32'(out_valid), 1);
            check_eq("t5_stall_data", 32'(out_data), 32'(held));
            check_eq("t5_stall_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("t5_idle_ready", 32'(in_ready), 1);
        check_eq("t5_idle_valid", 32'(out_valid), 0);
        check_eq("t5_idle_busy", 32'(busy), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("t5_next_busy", 32'(busy), 1);
        wait_idle();

        // reset during pass 2 of a 5-pass command
        send(4'b1011, 2'd1, 1'b0, 3'd5);
        @(posedge clk); #1;
        check_eq("t6_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_out_valid", 32'(out_valid), 0);
        check_eq("t6_busy_rst", 32'(busy), 0);
        check_eq("t6_out_data", 32'(out_data), 0);
        check_eq("t6_sh_s", 32'(sh_s), 0);
        check_eq("t6_sh_a", 32'(sh_a), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_eq("t6_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        send(4'b1111, 2'd2, 1'b0, 3'd5);
        wait_idle();
        send(4'b0011, 2'd3, 1'b1, 3'd2);
        wait_idle();
        send(4'b0101, 2'd0, 1'b0, 3'd2);
        wait_idle();

        repeat (3) @(posedge clk);
        check_eq("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
